// File: rtl/uart_frame_ctrl.sv
`timescale 1ns/1ps
// Frame parser for a UART byte stream: SYNC, ADDR, LEN, payload, XOR checksum.
// Buffers the payload and, once the checksum matches, bursts it out as register writes.
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 57280
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data_in,
  input  logic       i_valid_in,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_ok,
  output logic       o_err_csum,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_err_overrun,
  output logic       o_busy
);

  localparam int          BUF_AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          CNT_W    = BUF_AW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      tcnt, tcnt_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [7:0]       base_addr, base_nxt;
  logic [7:0]       len_q, len_nxt;
  logic [7:0]       csum, csum_nxt;
  logic             wr_en_nxt, frame_ok_nxt, busy_nxt;
  logic [7:0]       wr_addr_nxt, wr_data_nxt;
  logic             err_csum_nxt, err_len_nxt, err_timeout_nxt, err_overrun_nxt;
  logic             buf_we;
  logic [7:0]       buf_mem [2**BUF_AW];

  always_comb begin
    state_nxt       = state;
    tcnt_nxt        = tcnt;
    idx_nxt         = idx;
    base_nxt        = base_addr;
    len_nxt         = len_q;
    csum_nxt        = csum;
    wr_en_nxt       = 1'b0;
    wr_addr_nxt     = o_wr_addr;
    wr_data_nxt     = o_wr_data;
    frame_ok_nxt    = 1'b0;
    err_csum_nxt    = 1'b0;
    err_len_nxt     = 1'b0;
    err_timeout_nxt = 1'b0;
    err_overrun_nxt = 1'b0;
    buf_we          = 1'b0;

    // Inter-byte watchdog; an arriving byte always beats expiry.
    if ((state inside {S_ADDR, S_LEN, S_PAYLOAD, S_CSUM}) && !i_valid_in) begin
      if (tcnt == TMO_LAST) begin
        err_timeout_nxt = 1'b1;
        tcnt_nxt        = '0;
        state_nxt       = S_IDLE;
      end else begin
        tcnt_nxt = tcnt + 16'd1;
      end
    end

    case (state)
      S_IDLE: begin
        if (i_valid_in && (i_data_in == SYNC_BYTE)) begin
          tcnt_nxt  = '0;
          idx_nxt   = '0;
          csum_nxt  = '0;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_valid_in) begin
          tcnt_nxt  = '0;
          base_nxt  = i_data_in;
          csum_nxt  = i_data_in;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (i_valid_in) begin
          tcnt_nxt = '0;
          if ((i_data_in == 8'd0) || (int'(i_data_in) > MAX_LEN)) begin
            err_len_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            len_nxt   = i_data_in;
            csum_nxt  = csum ^ i_data_in;
            idx_nxt   = '0;
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_valid_in) begin
          tcnt_nxt = '0;
          buf_we   = 1'b1;
          csum_nxt = csum ^ i_data_in;
          if (8'(idx) == len_q - 8'd1) begin
            idx_nxt   = '0;
            state_nxt = S_CSUM;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (i_valid_in) begin
          tcnt_nxt = '0;
          if (i_data_in == csum) begin
            // First write leaves with the checksum edge so the burst starts next cycle.
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = base_addr;
            wr_data_nxt  = buf_mem[0];
            frame_ok_nxt = (len_q == 8'd1);
            idx_nxt      = 1;
            state_nxt    = S_DRAIN;
          end else begin
            err_csum_nxt = 1'b1;
            state_nxt    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        err_overrun_nxt = i_valid_in;
        if (8'(idx) == len_q) begin
          state_nxt = S_IDLE;
        end else begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = base_addr + 8'(idx);
          wr_data_nxt  = buf_mem[idx[BUF_AW-1:0]];
          frame_ok_nxt = (8'(idx) == len_q - 8'd1);
          idx_nxt      = idx + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      idx           <= '0;
      base_addr     <= '0;
      len_q         <= '0;
      csum          <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_frame_ok    <= 1'b0;
      o_err_csum    <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_nxt;
      tcnt          <= tcnt_nxt;
      idx           <= idx_nxt;
      base_addr     <= base_nxt;
      len_q         <= len_nxt;
      csum          <= csum_nxt;
      o_wr_en       <= wr_en_nxt;
      o_wr_addr     <= wr_addr_nxt;
      o_wr_data     <= wr_data_nxt;
      o_frame_ok    <= frame_ok_nxt;
      o_err_csum    <= err_csum_nxt;
      o_err_len     <= err_len_nxt;
      o_err_timeout <= err_timeout_nxt;
      o_err_overrun <= err_overrun_nxt;
      o_busy        <= busy_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) begin
      buf_mem[idx[BUF_AW-1:0]] <= i_data_in;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
`timescale 1ns/1ps
// Directed bench for uart_frame_ctrl: good frames, wrap, errors, timeout, overrun, reset abort.
module tb_uart_frame_ctrl;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       wr_en, frame_ok, err_csum, err_len, err_timeout, err_overrun, busy;
  logic [7:0] wr_addr, wr_data;

  uart_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_data_in(data_in), .i_valid_in(valid_in),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_ok(frame_ok), .o_err_csum(err_csum), .o_err_len(err_len),
    .o_err_timeout(err_timeout), .o_err_overrun(err_overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc;
  logic [15:0] wr_q[$];
  int          wr_cyc_q[$];
  int n_ok, n_ecs, n_elen, n_eto, n_eov;
  int ok_cyc, eto_cyc, eov_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back({wr_addr, wr_data});
      wr_cyc_q.push_back(cyc);
    end
    if (frame_ok)    begin n_ok++;  ok_cyc  = cyc; end
    if (err_csum)    n_ecs++;
    if (err_len)     n_elen++;
    if (err_timeout) begin n_eto++; eto_cyc = cyc; end
    if (err_overrun) begin n_eov++; eov_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wr_q.delete();
    wr_cyc_q.delete();
    n_ok = 0; n_ecs = 0; n_elen = 0; n_eto = 0; n_eov = 0;
    ok_cyc = -1; eto_cyc = -1; eov_cyc = -1;
  endtask

  // Called at a falling edge; drives one byte for exactly one cycle.
  task automatic send(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [7:0] a, input logic [7:0] d);
    if (i < wr_q.size()) chk(tag, 32'(wr_q[i]), 32'({a, d}));
    else                 chk(tag, 32'hDEAD, 32'({a, d}));
  endtask

  logic [7:0] pay [16];
  logic [7:0] cs;
  int         k_csum;

  initial begin
    clr_log();
    idle(3);
    rst = 1'b0;
    chk("reset_outputs",
        {wr_en, wr_addr, wr_data, frame_ok, err_csum, err_len, err_timeout, err_overrun, busy},
        '0);

    // Basic two-byte frame
    clr_log();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    k_csum = last_cyc;
    idle(4);
    chk("basic_nwr", wr_q.size(), 2);
    chk_wr("basic_wr0", 0, 8'h10, 8'h11);
    chk_wr("basic_wr1", 1, 8'h11, 8'h22);
    chk("basic_first_lat", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, k_csum + 1);
    chk("basic_last_lat",  (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : -1, k_csum + 2);
    chk("basic_ok_cnt", n_ok, 1);
    chk("basic_ok_cyc", ok_cyc, k_csum + 2);
    chk("basic_idle", busy, 0);
    chk("basic_hold", {wr_addr, wr_data}, 16'h1122);

    // Address wraps from FF to 00
    clr_log();
    send(8'hA5); send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB); send(8'hEC);
    idle(4);
    chk("wrap_nwr", wr_q.size(), 2);
    chk_wr("wrap_wr0", 0, 8'hFF, 8'hAA);
    chk_wr("wrap_wr1", 1, 8'h00, 8'hBB);

    // Checksum mismatch
    clr_log();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
    idle(4);
    chk("csum_err_cnt", n_ecs, 1);
    chk("csum_err_nwr", wr_q.size(), 0);
    chk("csum_err_idle", busy, 0);

    // Length too big, then zero
    clr_log();
    send(8'hA5); send(8'h10); send(8'h11);
    idle(3);
    chk("len17_err", n_elen, 1);
    chk("len17_idle", busy, 0);
    clr_log();
    send(8'hA5); send(8'h10); send(8'h00);
    idle(3);
    chk("len0_err", n_elen, 1);

    // Leading noise byte ignored
    clr_log();
    send(8'h33); send(8'hA5); send(8'h20); send(8'h01); send(8'h55); send(8'h74);
    idle(3);
    chk("noise_nwr", wr_q.size(), 1);
    chk_wr("noise_wr0", 0, 8'h20, 8'h55);
    chk("noise_ok", n_ok, 1);

    // Inter-byte timeout
    clr_log();
    send(8'hA5); send(8'h10);
    k_csum = last_cyc;
    idle(TMO + 5);
    chk("tmo_cnt", n_eto, 1);
    chk("tmo_cyc", eto_cyc, k_csum + TMO + 1);
    chk("tmo_idle", busy, 0);

    // Byte arriving in the expiry cycle wins
    clr_log();
    send(8'hA5); send(8'h10);
    idle(TMO - 1);
    send(8'h01); send(8'h5A); send(8'h4B);
    idle(3);
    chk("tmo_race_cnt", n_eto, 0);
    chk("tmo_race_nwr", wr_q.size(), 1);
    chk_wr("tmo_race_wr0", 0, 8'h10, 8'h5A);

    // Full 16-byte frame with a byte injected mid-burst
    clr_log();
    cs = 8'h80 ^ 8'h10;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i * 7 + 3);
      cs     = cs ^ pay[i];
    end
    send(8'hA5); send(8'h80); send(8'h10);
    for (int i = 0; i < 16; i++) send(pay[i]);
    send(cs);
    idle(4);
    send(8'hA5);
    k_csum = last_cyc;
    idle(20);
    chk("ovr_nwr", wr_q.size(), 16);
    for (int i = 0; i < 16; i++) chk_wr($sformatf("ovr_wr%0d", i), i, 8'(8'h80 + i), pay[i]);
    chk("ovr_cnt", n_eov, 1);
    chk("ovr_cyc", eov_cyc, k_csum + 1);
    chk("ovr_ok", n_ok, 1);
    chk("ovr_idle", busy, 0);

    // Reset during the third write of a 4-byte burst
    clr_log();
    send(8'hA5); send(8'h40); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h40);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_outputs",
        {wr_en, wr_addr, wr_data, frame_ok, err_csum, err_len, err_timeout, err_overrun, busy},
        '0);
    idle(6);
    chk("rst_nwr", wr_q.size(), 3);
    chk("rst_no_ok", n_ok, 0);
    chk("rst_no_err", n_ecs + n_elen + n_eto + n_eov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
